// File: rtl/sdram_responder.sv
// rtl/sdram_responder.sv - SDRAM pin-side device model: command decode, per-bank rows, word array, CAS-latency read path, error flags
module sdram_responder #(
  parameter int MEM_AW = 16,
  parameter int TRCD   = 3,
  parameter int TRP    = 3,
  parameter int TRFC   = 7
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sdram_cle,
  input  logic        sdram_cs,
  input  logic        sdram_ras,
  input  logic        sdram_cas,
  input  logic        sdram_we,
  input  logic        sdram_dqm,
  input  logic [1:0]  sdram_ba,
  input  logic [12:0] sdram_a,
  input  logic [31:0] sdram_dqi,
  output logic [31:0] sdram_dqo,
  output logic        dq_oe,
  output logic        err_flag,
  output logic [2:0]  err_code
);
  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_ACT  = 4'b0011;
  localparam logic [3:0] CMD_RD   = 4'b0101;
  localparam logic [3:0] CMD_WR   = 4'b0100;
  localparam logic [3:0] CMD_TERM = 4'b0110;
  localparam logic [3:0] CMD_PRE  = 4'b0010;
  localparam logic [3:0] CMD_REF  = 4'b0001;
  localparam logic [3:0] CMD_LMR  = 4'b0000;
  localparam int CW = 8;
  // Countdowns load T-1 so the dependent command is legal exactly T edges later.
  localparam logic [CW-1:0] TRCD_LD = CW'((TRCD > 0) ? TRCD - 1 : 0);
  localparam logic [CW-1:0] TRP_LD  = CW'((TRP  > 0) ? TRP  - 1 : 0);
  localparam logic [CW-1:0] TRFC_LD = CW'((TRFC > 0) ? TRFC - 1 : 0);

  logic [31:0]       mem [2**MEM_AW];
  logic [3:0]        cmd;
  logic [3:0]        bank_open;
  logic [12:0]       bank_row [4];
  logic [CW-1:0]     trcd_cnt [4];
  logic [CW-1:0]     trp_cnt  [4];
  logic [CW-1:0]     trfc_cnt;
  logic              mode_cl3;
  logic [1:0]        mode_bl;
  logic              mode_wsingle;
  logic              bst_act, bst_wr;
  logic [2:0]        bst_left, bst_k, bst_mask;
  logic [9:0]        bst_col;
  logic [1:0]        bst_ba;
  logic [12:0]       bst_row;
  logic              p1_v, p2_v;
  logic [MEM_AW-1:0] p1_addr, p2_addr;
  logic              err_now;
  logic [2:0]        err_val;
  logic              ok, do_act, do_rd, do_wr, do_term, do_pre, do_ref, do_lmr, cont;
  logic              issue_v, mem_we, sel_v;
  logic [MEM_AW-1:0] new_addr, cont_addr, issue_addr, mem_addr, sel_addr;
  logic [2:0]        cur_mask;

  function automatic logic [MEM_AW-1:0] word_addr(input logic [12:0] row, input logic [1:0] b,
                                                  input logic [9:0] col);
    logic [24:0] full;
    full = {row, b, col};
    return full[MEM_AW-1:0];
  endfunction

  function automatic logic [9:0] wrap_col(input logic [9:0] col, input logic [2:0] mask,
                                          input logic [2:0] k);
    logic [9:0] m;
    m = {7'd0, mask};
    return (col & ~m) | ((col + {7'd0, k}) & m);
  endfunction

  assign cmd      = {sdram_cs, sdram_ras, sdram_cas, sdram_we};
  assign cur_mask = 3'((4'd1 << mode_bl) - 4'd1);

  always_comb begin
    err_now = 1'b0;
    err_val = 3'd0;
    if (!sdram_cs && cmd != CMD_NOP) begin
      if (trfc_cnt != '0) begin
        err_now = 1'b1; err_val = 3'd5;
      end else begin
        case (cmd)
          CMD_ACT: if (bank_open[sdram_ba]) begin
                     err_now = 1'b1; err_val = 3'd2;
                   end else if (trp_cnt[sdram_ba] != '0) begin
                     err_now = 1'b1; err_val = 3'd4;
                   end
          CMD_RD, CMD_WR: if (!bank_open[sdram_ba]) begin
                     err_now = 1'b1; err_val = 3'd1;
                   end else if (trcd_cnt[sdram_ba] != '0) begin
                     err_now = 1'b1; err_val = 3'd3;
                   end
          CMD_REF: if (|bank_open) begin err_now = 1'b1; err_val = 3'd5; end
          CMD_LMR: if (|bank_open) begin err_now = 1'b1; err_val = 3'd6; end
          default: ;
        endcase
      end
    end
  end

  assign ok      = sdram_cle && !sdram_cs && !err_now;
  assign do_act  = ok && cmd == CMD_ACT;
  assign do_rd   = ok && cmd == CMD_RD;
  assign do_wr   = ok && cmd == CMD_WR;
  assign do_term = ok && cmd == CMD_TERM;
  assign do_pre  = ok && cmd == CMD_PRE;
  assign do_ref  = ok && cmd == CMD_REF;
  assign do_lmr  = ok && cmd == CMD_LMR;
  assign cont    = sdram_cle && bst_act && !(do_rd || do_wr || do_term);

  assign new_addr   = word_addr(bank_row[sdram_ba], sdram_ba, sdram_a[9:0]);
  assign cont_addr  = word_addr(bst_row, bst_ba, wrap_col(bst_col, bst_mask, bst_k));
  assign issue_v    = do_rd || (cont && !bst_wr);
  assign issue_addr = do_rd ? new_addr : cont_addr;
  assign mem_we     = rst_n && !sdram_dqm && (do_wr || (cont && bst_wr));
  assign mem_addr   = do_wr ? new_addr : cont_addr;
  assign sel_v      = mode_cl3 ? p2_v : p1_v;
  assign sel_addr   = mode_cl3 ? p2_addr : p1_addr;

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= sdram_dqi;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_open    <= '0;
      trfc_cnt     <= '0;
      for (int b = 0; b < 4; b++) begin
        bank_row[b] <= '0;
        trcd_cnt[b] <= '0;
        trp_cnt[b]  <= '0;
      end
      mode_cl3     <= 1'b0;
      mode_bl      <= 2'd0;
      mode_wsingle <= 1'b1;
      bst_act      <= 1'b0;
      bst_wr       <= 1'b0;
      bst_left     <= '0;
      bst_k        <= '0;
      bst_mask     <= '0;
      bst_col      <= '0;
      bst_ba       <= '0;
      bst_row      <= '0;
      p1_v         <= 1'b0;
      p2_v         <= 1'b0;
      p1_addr      <= '0;
      p2_addr      <= '0;
      sdram_dqo    <= '0;
      dq_oe        <= 1'b0;
      err_flag     <= 1'b0;
      err_code     <= '0;
    end else if (sdram_cle) begin
      if (trfc_cnt != '0) trfc_cnt <= trfc_cnt - 1'b1;
      for (int b = 0; b < 4; b++) begin
        if (trcd_cnt[b] != '0) trcd_cnt[b] <= trcd_cnt[b] - 1'b1;
        if (trp_cnt[b] != '0)  trp_cnt[b]  <= trp_cnt[b] - 1'b1;
        if (do_pre && (sdram_a[10] || sdram_ba == 2'(b))) begin
          bank_open[b] <= 1'b0;
          trp_cnt[b]   <= TRP_LD;
        end
      end
      if (do_act) begin
        bank_open[sdram_ba] <= 1'b1;
        bank_row[sdram_ba]  <= sdram_a;
        trcd_cnt[sdram_ba]  <= TRCD_LD;
      end
      if (do_ref) trfc_cnt <= TRFC_LD;
      if (do_lmr) begin
        mode_cl3     <= sdram_a[6:4] == 3'd3;
        mode_bl      <= sdram_a[2] ? 2'd0 : sdram_a[1:0];
        mode_wsingle <= sdram_a[9];
      end

      if (do_rd || do_wr) begin
        bst_act  <= (cur_mask != 3'd0) && !(do_wr && mode_wsingle);
        bst_wr   <= do_wr;
        bst_left <= cur_mask;
        bst_k    <= 3'd1;
        bst_mask <= cur_mask;
        bst_col  <= sdram_a[9:0];
        bst_ba   <= sdram_ba;
        bst_row  <= bank_row[sdram_ba];
      end else if (do_term) begin
        bst_act <= 1'b0;
      end else if (cont) begin
        bst_k    <= bst_k + 3'd1;
        bst_left <= bst_left - 3'd1;
        if (bst_left == 3'd1) bst_act <= 1'b0;
      end

      // Two-stage address pipe; CL selects which stage feeds the output register.
      p1_v    <= issue_v;
      p1_addr <= issue_addr;
      p2_v    <= p1_v;
      p2_addr <= p1_addr;
      dq_oe   <= sel_v;
      if (sel_v) sdram_dqo <= mem[sel_addr];

      if (err_now && !err_flag) begin
        err_flag <= 1'b1;
        err_code <= err_val;
      end
    end
  end
endmodule
